grom_mem_arbiter: RTL and testbench

Two-port memory arbiter sharing the single synchronous RAM of the grom8 system between the CPU bus master and a second master, either the loader or the debug port. Each master issues one read or write at a time through a req/gnt handshake; read data returns with an rvalid pulse. The arbiter sequences the RAM access itself, with a programmable read latency. It sits between the masters and the RAM primitive.

---
 rtl/grom_bus_pkg.sv | 19 +
 rtl/grom_rr_pick.sv | 37 +++
 rtl/grom_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_grom_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grom_bus_pkg.sv
// Shared definitions for the grom8 memory bus: arbiter state encoding,
// default bus widths and master index constants.
package grom_bus_pkg;

    localparam int unsigned GROM_ADDR_W = 12;
    localparam int unsigned GROM_DATA_W = 8;

    // Master indices, also the encoding of the winner and last-grant pointer
    localparam logic M_CPU = 1'b0;
    localparam logic M_LDR = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/grom_rr_pick.sv
// Combinational 2-way request picker for the grom8 memory arbiter.
// Default: round-robin on the last-grant pointer.
// GROM_ARB_FIXED_PRIO_EN defined: master 0 always wins ties, pointer ignored.
module grom_rr_pick
    import grom_bus_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic winner_o,
    output logic valid_o
);

    // Pick a winner among the pending requests
    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = M_CPU;
`ifdef GROM_ARB_FIXED_PRIO_EN
        if (!req0_i && req1_i) begin
            winner_o = M_LDR;
        end
`else
        if (req0_i && req1_i) begin
            // Tie goes to the master that was not granted last
            winner_o = ~last_i;
        end else if (req1_i) begin
            winner_o = M_LDR;
        end
`endif
    end

`ifdef GROM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_i;
`endif

endmodule

// File: rtl/grom_mem_arbiter.sv
// Two-master arbiter in front of the single synchronous grom8 RAM.
// Sequences each access as IDLE -> ISSUE (-> WAIT x MEM_LAT -> RESP) -> IDLE.
// MEM_LAT (RAM read latency) is legal in 1..3.
// Optional build macro GROM_ARB_FIXED_PRIO_EN: master 0 always wins ties and
// the last-grant pointer is removed.
module grom_mem_arbiter
    import grom_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = GROM_ADDR_W,
    parameter int unsigned DATA_W  = GROM_DATA_W,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              we0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Final WAIT count: mem_rdata is valid in the last WAIT cycle
    localparam logic [1:0] LastCnt = 2'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic pick_winner;
    logic pick_valid;
    logic last_ptr;

    grom_rr_pick u_pick (
        .req0_i   (req0),
        .req1_i   (req1),
        .last_i   (last_ptr),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

`ifdef GROM_ARB_FIXED_PRIO_EN
    assign last_ptr = M_LDR;
`else
    logic last_q, last_d;

    // Last-grant pointer follows every grant
    always_comb begin
        last_d = last_q;
        if (state_q == StIdle && pick_valid) begin
            last_d = pick_winner;
        end
    end

    // Pointer register; reset to master 1 so master 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= M_LDR;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_ptr = last_q;
`endif

    // Next-state logic and request/response datapath
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    win_d = pick_winner;
                    if (pick_winner == M_LDR) begin
                        mem_addr_d  = addr1;
                        we_d        = we1;
                        mem_wdata_d = wdata1;
                    end else begin
                        mem_addr_d  = addr0;
                        we_d        = we0;
                        mem_wdata_d = wdata0;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (we_q) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = 2'd0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == LastCnt) begin
                    // Register the RAM output so it is presented with rvalid in RESP
                    rdata_d = mem_rdata;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            win_q       <= M_CPU;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Strobes decode straight from the state register, so reset kills them at once
    always_comb begin
        gnt0      = (state_q == StIssue) && (win_q == M_CPU);
        gnt1      = (state_q == StIssue) && (win_q == M_LDR);
        rvalid0   = (state_q == StResp) && (win_q == M_CPU);
        rvalid1   = (state_q == StResp) && (win_q == M_LDR);
        mem_we    = (state_q == StIssue) && we_q;
        busy      = (state_q != StIdle);
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        rdata     = rdata_q;
    end

endmodule

// File: tb/tb_grom_mem_arbiter.sv
// Directed, table-driven bench for grom_mem_arbiter (default round-robin build).
// Instance u_l1 uses MEM_LAT=1, instance u_l3 uses MEM_LAT=3; both share stimulus.
module tb_grom_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        tb_init;
    logic        req0, we0, req1, we1;
    logic [11:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;

    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic [11:0] mem_addr;

    logic        gnt0_3, gnt1_3, rvalid0_3, rvalid1_3, mem_we_3, busy_3;
    logic [7:0]  rdata_3, mem_wdata_3, mem_rdata_3;
    logic [11:0] mem_addr_3;

    int total = 0;
    int bad   = 0;

    grom_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .MEM_LAT(1)) u_l1 (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    grom_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .MEM_LAT(3)) u_l3 (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .gnt0(gnt0_3), .gnt1(gnt1_3), .rvalid0(rvalid0_3), .rvalid1(rvalid1_3),
        .rdata(rdata_3), .mem_addr(mem_addr_3), .mem_we(mem_we_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3), .busy(busy_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        case (a)
            'h123:   return 8'h5A;
            'h010:   return 8'h11;
            'h020:   return 8'h22;
            'h234:   return 8'h77;
            default: return 8'h00;
        endcase
    endfunction

    // RAM models: synchronous read with 1 and 3 cycles of latency
    logic [7:0] mem1 [4096];
    logic [7:0] mem3 [4096];
    logic [7:0] p1;
    logic [7:0] p3 [3];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 4096; i++) begin
                mem1[i] <= init_val(i);
                mem3[i] <= init_val(i);
            end
        end else begin
            if (mem_we) mem1[mem_addr] <= mem_wdata;
            if (mem_we_3) mem3[mem_addr_3] <= mem_wdata_3;
        end
        p1    <= mem1[mem_addr];
        p3[0] <= mem3[mem_addr_3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata   = p1;
    assign mem_rdata_3 = p3[2];

    typedef struct {
        logic        rst;
        logic        r0;
        logic [11:0] a0;
        logic        w0;
        logic [7:0]  d0;
        logic        r1;
        logic [11:0] a1;
        logic        w1;
        logic [7:0]  d1;
        logic        g0, g1, v0, v1;
        logic [7:0]  rd;
        logic        mwe;
        logic [11:0] ma;
        logic [7:0]  md;
        logic        bsy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic rst, input logic r0, input logic [11:0] a0, input logic w0,
        input logic [7:0] d0, input logic r1, input logic [11:0] a1, input logic w1,
        input logic [7:0] d1, input logic g0, input logic g1, input logic v0,
        input logic v1, input logic [7:0] rd, input logic mwe, input logic [11:0] ma,
        input logic [7:0] md, input logic bsy);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.a0 = a0; v.w0 = w0; v.d0 = d0;
        v.r1 = r1; v.a1 = a1; v.w1 = w1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd;
        v.mwe = mwe; v.ma = ma; v.md = md; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; tb_init = 1'b1;
        req0 = 0; addr0 = 0; we0 = 0; wdata0 = 0;
        req1 = 0; addr1 = 0; we1 = 0; wdata1 = 0;

        // rst, req0/addr0/we0/wdata0, req1/addr1/we1/wdata1 |
        // gnt0 gnt1 rvalid0 rvalid1 rdata mem_we mem_addr mem_wdata busy
        vt.push_back(mk(0, 1,12'h123,0,8'h00, 0,12'h000,0,8'h00, 0,0,0,0,8'h00,0,12'h000,8'h00,0));
        vt.push_back(mk(0, 1,12'h123,0,8'h00, 0,12'h000,0,8'h00, 1,0,0,0,8'h00,0,12'h123,8'h00,1));
        vt.push_back(mk(0, 0,12'h123,0,8'h00, 0,12'h000,0,8'h00, 0,0,0,0,8'h00,0,12'h123,8'h00,1));
        vt.push_back(mk(0, 0,12'h000,0,8'h00, 0,12'h000,0,8'h00, 0,0,1,0,8'h5A,0,12'h123,8'h00,1));
        vt.push_back(mk(0, 0,12'h000,0,8'h00, 1,12'hFFF,1,8'hA5, 0,0,0,0,8'h5A,0,12'h123,8'h00,0));
        vt.push_back(mk(0, 0,12'h000,0,8'h00, 1,12'hFFF,1,8'hA5, 0,1,0,0,8'h5A,1,12'hFFF,8'hA5,1));
        vt.push_back(mk(0, 1,12'hFFF,0,8'h00, 0,12'h000,0,8'h00, 0,0,0,0,8'h5A,0,12'hFFF,8'hA5,0));
        vt.push_back(mk(0, 1,12'hFFF,0,8'h00, 0,12'h000,0,8'h00, 1,0,0,0,8'h5A,0,12'hFFF,8'h00,1));
        vt.push_back(mk(0, 0,12'h000,0,8'h00, 0,12'h000,0,8'h00, 0,0,0,0,8'h5A,0,12'hFFF,8'h00,1));
        vt.push_back(mk(0, 0,12'h000,0,8'h00, 0,12'h000,0,8'h00, 0,0,1,0,8'hA5,0,12'hFFF,8'h00,1));
        vt.push_back(mk(1, 0,12'h000,0,8'h00, 0,12'h000,0,8'h00, 0,0,0,0,8'h00,0,12'h000,8'h00,0));
        // Both masters read continuously: grants alternate 0,1,0,1
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 0,0,0,0,8'h00,0,12'h000,8'h00,0));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 1,0,0,0,8'h00,0,12'h010,8'h00,1));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 0,0,0,0,8'h00,0,12'h010,8'h00,1));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 0,0,1,0,8'h11,0,12'h010,8'h00,1));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 0,0,0,0,8'h11,0,12'h010,8'h00,0));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 0,1,0,0,8'h11,0,12'h020,8'h00,1));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 0,0,0,0,8'h11,0,12'h020,8'h00,1));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 0,0,0,1,8'h22,0,12'h020,8'h00,1));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 0,0,0,0,8'h22,0,12'h020,8'h00,0));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 1,0,0,0,8'h22,0,12'h010,8'h00,1));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 0,0,0,0,8'h22,0,12'h010,8'h00,1));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 0,0,1,0,8'h11,0,12'h010,8'h00,1));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 0,0,0,0,8'h11,0,12'h010,8'h00,0));
        vt.push_back(mk(0, 1,12'h010,0,8'h00, 1,12'h020,0,8'h00, 0,1,0,0,8'h11,0,12'h020,8'h00,1));
        vt.push_back(mk(0, 0,12'h000,0,8'h00, 0,12'h000,0,8'h00, 0,0,0,0,8'h11,0,12'h020,8'h00,1));
        vt.push_back(mk(0, 0,12'h000,0,8'h00, 0,12'h000,0,8'h00, 0,0,0,1,8'h22,0,12'h020,8'h00,1));
        vt.push_back(mk(0, 0,12'h000,0,8'h00, 0,12'h000,0,8'h00, 0,0,0,0,8'h22,0,12'h020,8'h00,0));

        next_cycle();
        next_cycle();
        reset = 1'b0; tb_init = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            reset = vt[i].rst;
            req0 = vt[i].r0; addr0 = vt[i].a0; we0 = vt[i].w0; wdata0 = vt[i].d0;
            req1 = vt[i].r1; addr1 = vt[i].a1; we1 = vt[i].w1; wdata1 = vt[i].d1;
            @(negedge clk);
            chk($sformatf("row%0d_gnt0", i), 32'(gnt0), 32'(vt[i].g0));
            chk($sformatf("row%0d_gnt1", i), 32'(gnt1), 32'(vt[i].g1));
            chk($sformatf("row%0d_rvalid0", i), 32'(rvalid0), 32'(vt[i].v0));
            chk($sformatf("row%0d_rvalid1", i), 32'(rvalid1), 32'(vt[i].v1));
            chk($sformatf("row%0d_rdata", i), 32'(rdata), 32'(vt[i].rd));
            chk($sformatf("row%0d_mem_we", i), 32'(mem_we), 32'(vt[i].mwe));
            chk($sformatf("row%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].ma));
            chk($sformatf("row%0d_mem_wdata", i), 32'(mem_wdata), 32'(vt[i].md));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(vt[i].bsy));
            next_cycle();
        end
        reset = 1'b0;

        // Reset during WAIT of a master 0 read (master 0 granted last beforehand)
        req0 = 1; addr0 = 12'h123; we0 = 0; wdata0 = 0; req1 = 0;
        next_cycle();
        @(negedge clk);
        chk("rst_pre_gnt0", 32'(gnt0), 32'd1);
        next_cycle();
        req0 = 0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d_rvalid0", k), 32'(rvalid0), 32'd0);
            chk($sformatf("rst_after%0d_busy", k), 32'(busy), 32'd0);
            next_cycle();
        end

        // Tie right after reset goes to master 0
        req0 = 1; addr0 = 12'h010; req1 = 1; addr1 = 12'h020; we1 = 0; wdata1 = 0;
        next_cycle();
        @(negedge clk);
        chk("tie_gnt0", 32'(gnt0), 32'd1);
        chk("tie_gnt1", 32'(gnt1), 32'd0);

        // Master 0 re-requests; master 1 drops its req before IDLE samples it
        next_cycle();
        addr0 = 12'h123;
        next_cycle();
        req1 = 0;
        @(negedge clk);
        chk("tie_rvalid0", 32'(rvalid0), 32'd1);
        chk("tie_rdata", 32'(rdata), 32'h11);
        next_cycle();
        @(negedge clk);
        chk("drop_idle_busy", 32'(busy), 32'd0);
        next_cycle();
        req0 = 0;
        @(negedge clk);
        chk("drop_gnt0", 32'(gnt0), 32'd1);
        chk("drop_gnt1", 32'(gnt1), 32'd0);
        chk("drop_mem_addr", 32'(mem_addr), 32'h123);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("drop%0d_gnt1", k), 32'(gnt1), 32'd0);
            chk($sformatf("drop%0d_rvalid1", k), 32'(rvalid1), 32'd0);
            chk($sformatf("drop%0d_rvalid0", k), 32'(rvalid0), (k == 1) ? 32'd1 : 32'd0);
            if (k == 1) chk("drop_rdata", 32'(rdata), 32'h5A);
        end

        // MEM_LAT=3: master 1 read, rvalid1 five cycles after sampling
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        req0 = 0; req1 = 1; addr1 = 12'h234; we1 = 0; wdata1 = 0;
        @(negedge clk);
        chk("lat3_idle_busy", 32'(busy_3), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 2) req1 = 0;
            @(negedge clk);
            chk($sformatf("lat3_c%0d_gnt1", k), 32'(gnt1_3), (k == 1) ? 32'd1 : 32'd0);
            chk($sformatf("lat3_c%0d_busy", k), 32'(busy_3), (k <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("lat3_c%0d_rvalid1", k), 32'(rvalid1_3), (k == 5) ? 32'd1 : 32'd0);
            chk($sformatf("lat3_c%0d_rvalid0", k), 32'(rvalid0_3), 32'd0);
            if (k == 5) chk("lat3_rdata", 32'(rdata_3), 32'h77);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
